// File: rtl/sys_mm_pkg.sv
// sys_mm_pkg: shared FSM state type, accumulator width and element-index helpers
// for the sys_tiled_mm matrix multiplier.
`default_nettype none

package sys_mm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

   function automatic int acc_width(input int width, input int n);
      return 2 * width + $clog2(n) + 1;
   endfunction

   function automatic int flat_idx(input int r, input int c, input int n);
      return r * n + c;
   endfunction

   // Element e (0..3, row-major inside the tile) of 2x2 tile (ti,tj).
   function automatic int tile_idx(input int ti, input int tj, input int e, input int n);
      return flat_idx(2 * ti + e / 2, 2 * tj + e % 2, n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sys_tiled_mm_mat2x2_mac.sv
// mat2x2_mac: combinational 2x2 tile product added onto four ACC_W accumulators.
`default_nettype none

module mat2x2_mac #(
   parameter int WIDTH  = 16,
   parameter int ACC_W  = 35,
   parameter int SIGNED = 0
) (
   input  logic [4*WIDTH-1:0] a_tile,
   input  logic [4*WIDTH-1:0] b_tile,
   input  logic [4*ACC_W-1:0] acc_in,
   output logic [4*ACC_W-1:0] acc_out
);

   localparam int EXT = ACC_W - WIDTH;

   logic [ACC_W-1:0] a_x [4];
   logic [ACC_W-1:0] b_x [4];

   for (genvar e = 0; e < 4; e++) begin : g_ext
      assign a_x[e] = {{EXT{(SIGNED != 0) && a_tile[e*WIDTH+WIDTH-1]}}, a_tile[e*WIDTH +: WIDTH]};
      assign b_x[e] = {{EXT{(SIGNED != 0) && b_tile[e*WIDTH+WIDTH-1]}}, b_tile[e*WIDTH +: WIDTH]};
   end

   // Low ACC_W bits of the extended product are exact for both signednesses.
   for (genvar r = 0; r < 2; r++) begin : g_r
      for (genvar c = 0; c < 2; c++) begin : g_c
         logic [ACC_W-1:0] p0;
         logic [ACC_W-1:0] p1;
         assign p0 = a_x[2*r]   * b_x[c];
         assign p1 = a_x[2*r+1] * b_x[2+c];
         assign acc_out[(2*r+c)*ACC_W +: ACC_W] = acc_in[(2*r+c)*ACC_W +: ACC_W] + p0 + p1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/sys_tiled_mm.sv
// sys_tiled_mm: N x N tiled matrix multiplier, C = A*B or C += A*B, start/busy/done.
// Define SYS_TILED_MM_SAT_EN to saturate results to OUT_W instead of truncating.
`default_nettype none

module sys_tiled_mm
   import sys_mm_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int N      = 4,
   parameter int OUT_W  = 16,
   parameter int SIGNED = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     acc_mode,
   input  logic [WIDTH*N*N-1:0]     A_flat,
   input  logic [WIDTH*N*N-1:0]     B_flat,
   output logic [OUT_W*N*N-1:0]     C_flat,
   output logic                     busy,
   output logic                     done
);

   localparam int T     = N / 2;
   localparam int NN    = N * N;
   localparam int ACC_W = acc_width(WIDTH, N);
   localparam int KW    = (T > 1) ? $clog2(T) : 1;
   localparam int EXT   = ACC_W - OUT_W;   // OUT_W is expected to be narrower than ACC_W
   localparam logic [KW-1:0] K_LAST = KW'(T - 1);

   state_t               state;
   logic [KW-1:0]        k;
   logic [WIDTH*NN-1:0]  a_reg;
   logic [WIDTH*NN-1:0]  b_reg;
   logic [ACC_W*NN-1:0]  acc;
   logic [ACC_W*NN-1:0]  acc_next;
   logic [ACC_W*NN-1:0]  c_ext;
   logic [OUT_W*NN-1:0]  c_conv;

   for (genvar ti = 0; ti < T; ti++) begin : g_row
      for (genvar tj = 0; tj < T; tj++) begin : g_col
         logic [4*WIDTH-1:0] a_tile;
         logic [4*WIDTH-1:0] b_tile;
         logic [4*ACC_W-1:0] acc_in;
         logic [4*ACC_W-1:0] acc_out;

         always_comb begin
            a_tile = '0;
            b_tile = '0;
            for (int e = 0; e < 4; e++) begin
               a_tile[e*WIDTH +: WIDTH] = a_reg[tile_idx(ti, int'(k), e, N)*WIDTH +: WIDTH];
               b_tile[e*WIDTH +: WIDTH] = b_reg[tile_idx(int'(k), tj, e, N)*WIDTH +: WIDTH];
            end
         end

         for (genvar e = 0; e < 4; e++) begin : g_el
            assign acc_in[e*ACC_W +: ACC_W] = acc[tile_idx(ti, tj, e, N)*ACC_W +: ACC_W];
            assign acc_next[tile_idx(ti, tj, e, N)*ACC_W +: ACC_W] = acc_out[e*ACC_W +: ACC_W];
         end

         mat2x2_mac #(
            .WIDTH  (WIDTH),
            .ACC_W  (ACC_W),
            .SIGNED (SIGNED)
         ) u_mac (
            .a_tile  (a_tile),
            .b_tile  (b_tile),
            .acc_in  (acc_in),
            .acc_out (acc_out)
         );
      end
   end

   for (genvar el = 0; el < NN; el++) begin : g_conv
      localparam int AB = el * ACC_W;
      localparam int CB = el * OUT_W;
      logic [OUT_W-1:0] conv_e;

      assign c_ext[AB +: ACC_W] = {{EXT{(SIGNED != 0) && C_flat[CB+OUT_W-1]}}, C_flat[CB +: OUT_W]};

`ifdef SYS_TILED_MM_SAT_EN
      if (SIGNED != 0) begin : g_sat_s
         logic [EXT:0] upper;
         assign upper = acc[AB+OUT_W-1 +: EXT+1];
         always_comb begin
            conv_e = acc[AB +: OUT_W];
            if (!((&upper) || !(|upper)))
               conv_e = upper[EXT] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
         end
      end else begin : g_sat_u
         always_comb begin
            conv_e = acc[AB +: OUT_W];
            if (|acc[AB+OUT_W +: EXT])
               conv_e = {OUT_W{1'b1}};
         end
      end
`else
      assign conv_e = acc[AB +: OUT_W];
`endif

      assign c_conv[CB +: OUT_W] = conv_e;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         k      <= '0;
         acc    <= '0;
         C_flat <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               busy <= 1'b0;
               // The done cycle is still part of the run; starts resume a cycle later.
               if (start && !done) begin
                  a_reg <= A_flat;
                  b_reg <= B_flat;
                  acc   <= acc_mode ? c_ext : '0;
                  k     <= '0;
                  busy  <= 1'b1;
                  state <= ST_MAC;
               end
            end
            ST_MAC: begin
               acc <= acc_next;
               if (k == K_LAST) begin
                  k     <= '0;
                  state <= ST_OUT;
               end else begin
                  k <= k + 1'b1;
               end
            end
            ST_OUT: begin
               C_flat <= c_conv;
               done   <= 1'b1;
               state  <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sys_tiled_mm.sv
// tb_sys_tiled_mm: directed vector table plus handshake/reset sequences for sys_tiled_mm.
`default_nettype none

module tb_sys_tiled_mm;

`ifdef SYS_TILED_MM_SAT_EN
   localparam logic [15:0] OVF_VAL = 16'hFFFF;
`else
   localparam logic [15:0] OVF_VAL = 16'h0000;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         start4 = 1'b0, acc4 = 1'b0;
   logic [255:0] a4 = '0, b4 = '0;
   logic [255:0] c4;
   logic         busy4, done4;

   logic         starts = 1'b0, accs = 1'b0;
   logic [255:0] as_ = '0, bs = '0;
   logic [255:0] cs;
   logic         busys, dones;

   logic         start6 = 1'b0, acc6 = 1'b0;
   logic [575:0] a6 = '0, b6 = '0;
   logic [575:0] c6;
   logic         busy6, done6;

   sys_tiled_mm #(.WIDTH(16), .N(4), .OUT_W(16), .SIGNED(0)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .acc_mode(acc4),
      .A_flat(a4), .B_flat(b4), .C_flat(c4), .busy(busy4), .done(done4));

   sys_tiled_mm #(.WIDTH(16), .N(4), .OUT_W(16), .SIGNED(1)) duts (
      .clk(clk), .rst_n(rst_n), .start(starts), .acc_mode(accs),
      .A_flat(as_), .B_flat(bs), .C_flat(cs), .busy(busys), .done(dones));

   sys_tiled_mm #(.WIDTH(16), .N(6), .OUT_W(16), .SIGNED(0)) dut6 (
      .clk(clk), .rst_n(rst_n), .start(start6), .acc_mode(acc6),
      .A_flat(a6), .B_flat(b6), .C_flat(c6), .busy(busy6), .done(done6));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [575:0] act, input logic [575:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] diag(input logic [15:0] v);
      logic [255:0] r = '0;
      for (int i = 0; i < 4; i++) r[(i*5)*16 +: 16] = v;
      return r;
   endfunction

   function automatic logic [255:0] seqm(input int m, input int off);
      logic [255:0] r = '0;
      for (int e = 0; e < 16; e++) r[e*16 +: 16] = 16'(m * (e + off));
      return r;
   endfunction

   function automatic logic [255:0] fill(input logic [15:0] v);
      logic [255:0] r = '0;
      for (int e = 0; e < 16; e++) r[e*16 +: 16] = v;
      return r;
   endfunction

   function automatic logic [255:0] colsum();
      logic [255:0] r = '0;
      for (int e = 0; e < 16; e++) r[e*16 +: 16] = 16'(24 + 4 * (e % 4));
      return r;
   endfunction

   function automatic logic [255:0] rowsum();
      logic [255:0] r = '0;
      for (int e = 0; e < 16; e++) r[e*16 +: 16] = 16'(16 * (e / 4) + 6);
      return r;
   endfunction

   // Start one run on dut4, scramble the inputs after the start edge, return cycles to done.
   task automatic run4(input logic [255:0] a, input logic [255:0] b, input logic acc, output int lat);
      @(negedge clk);
      a4 = a; b4 = b; acc4 = acc; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0; a4 = ~a; b4 = '1; acc4 = ~acc;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (done4) begin lat = i; break; end
      end
   endtask

   typedef struct {
      string        name;
      logic [255:0] a;
      logic [255:0] b;
      logic         acc;
      logic [255:0] exp;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int lat;
      int ndone;

      vecs[0] = '{"ident",  diag(16'd1), seqm(1, 1), 1'b0, seqm(1, 1)};
      vecs[1] = '{"accum",  diag(16'd1), seqm(1, 1), 1'b1, seqm(2, 1)};
      vecs[2] = '{"clear",  diag(16'd1), seqm(1, 1), 1'b0, seqm(1, 1)};
      vecs[3] = '{"diag2",  diag(16'd2), seqm(1, 0), 1'b0, seqm(2, 0)};
      vecs[4] = '{"ones",   fill(16'd1), fill(16'd1), 1'b0, fill(16'd4)};
      vecs[5] = '{"colsum", fill(16'd1), seqm(1, 0), 1'b0, colsum()};
      vecs[6] = '{"rowsum", seqm(1, 0), fill(16'd1), 1'b0, rowsum()};
      vecs[7] = '{"ovf",    fill(16'h0100), fill(16'h0100), 1'b0, fill(OVF_VAL)};

      repeat (3) @(posedge clk);
      #1;
      check("reset_c",    c4,    '0);
      check("reset_busy", busy4, '0);
      check("reset_done", done4, '0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 8; v++) begin
         run4(vecs[v].a, vecs[v].b, vecs[v].acc, lat);
         check({vecs[v].name, "_lat"},  32'(lat), 32'd3);
         check({vecs[v].name, "_busy_done"}, busy4, 1'b1);
         check({vecs[v].name, "_c"}, c4, vecs[v].exp);
         @(posedge clk); #1;
         check({vecs[v].name, "_busy_after"}, busy4, 1'b0);
         check({vecs[v].name, "_done_pulse"}, done4, 1'b0);
      end

      // Start pulse while busy is ignored: exactly one done.
      @(negedge clk);
      a4 = diag(16'd1); b4 = seqm(1, 1); acc4 = 1'b0; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      @(negedge clk);
      start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (done4) ndone++;
      end
      check("midstart_ndone", 32'(ndone), 32'd1);
      check("midstart_c", c4, seqm(1, 1));

      // Reset on the second MAC edge aborts the run.
      @(negedge clk);
      a4 = fill(16'd1); b4 = fill(16'd1); acc4 = 1'b0; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("abort_c_now", c4, '0);
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (done4) ndone++;
      end
      check("abort_ndone", 32'(ndone), 32'd0);
      check("abort_c",     c4,    '0);
      check("abort_busy",  busy4, '0);

      run4(diag(16'd1), seqm(1, 1), 1'b0, lat);
      check("post_reset_lat", 32'(lat), 32'd3);
      check("post_reset_c",   c4, seqm(1, 1));

      // start held high: next run accepted on the cycle after done.
      @(negedge clk);
      a4 = diag(16'd2); b4 = seqm(1, 0); acc4 = 1'b0; start4 = 1'b1;
      lat = -1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (done4) begin lat = i; break; end
      end
      check("held_first_done", 32'(lat >= 0), 32'd1);
      @(posedge clk); #1;
      check("held_gap_busy", busy4, 1'b0);
      @(posedge clk); #1;
      check("held_restart_busy", busy4, 1'b1);
      start4 = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (done4) begin lat = i; break; end
      end
      check("held_second_lat", 32'(lat), 32'd3);
      check("held_second_c", c4, seqm(2, 0));

      // Signed: (-I) * B with B[e]=e gives C[e] = -e.
      @(negedge clk);
      as_ = diag(16'hFFFF); bs = seqm(1, 0); accs = 1'b0; starts = 1'b1;
      @(posedge clk); #1;
      starts = 1'b0; as_ = '0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (dones) begin lat = i; break; end
      end
      check("signed_lat", 32'(lat), 32'd3);
      check("signed_c",   cs, seqm(-1, 0));
      check("signed_c5",  cs[5*16 +: 16], 16'hFFFB);

      // N=6 with all ones: each element is 6, latency 4.
      @(negedge clk);
      for (int e = 0; e < 36; e++) begin
         a6[e*16 +: 16] = 16'd1;
         b6[e*16 +: 16] = 16'd1;
      end
      acc6 = 1'b0; start6 = 1'b1;
      @(posedge clk); #1;
      start6 = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (done6) begin lat = i; break; end
      end
      check("n6_lat", 32'(lat), 32'd4);
      begin
         logic [575:0] exp6;
         for (int e = 0; e < 36; e++) exp6[e*16 +: 16] = 16'd6;
         check("n6_c", c6, exp6);
      end
      @(posedge clk); #1;
      check("n6_busy_after", busy6, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sys_tiled_mm.md
# sys_tiled_mm

Parametrised N×N tiled matrix multiplier for the systolic/matrix datapath. Computes C = A·B, or C = C + A·B in accumulate mode. It uses a (N/2)² grid of 2×2 tile MAC units that step through the shared dimension one 2×2 tile per cycle. Inputs are captured at start, accumulation is full-width, and a start/busy/done handshake controls operation; fixed-size 4×4 callers instantiate it with N=4.

## Interface
- WIDTH, 16: element width of A and B.
- N, 4: matrix dimension; must be even and ≥ 2. T = N/2 tiles per side.
- OUT_W, 16: element width of C.
- SIGNED, 0: 1 = two's-complement operands and result; 0 = unsigned.
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- acc_mode  in  1  sampled with start; 1 = accumulate onto current C_flat.
- A_flat  in  WIDTH·N²  row-major; element (r,c) at [(r·N+c)·WIDTH +: WIDTH].
- B_flat  in  WIDTH·N²  same packing as A_flat.
- C_flat  out  OUT_W·N²  registered result; same packing with OUT_W.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse; C_flat is valid from the same edge.

## Operation
- ACC_W = 2·WIDTH + $clog2(N) + 1. Every product and sum is formed at ACC_W, sign- or zero-extended per SIGNED.
- FSM states: IDLE, MAC, OUT.
- IDLE, start=1: register A_flat and B_flat. Set k=0 and go to MAC.
  - acc_mode=0: clear all N² accumulators.
  - acc_mode=1: load the accumulators with C_flat, extended per SIGNED.
- MAC, each cycle: output tile (i,j) adds A tile (i,k) × B tile (k,j) into its accumulators, then k++. After k=T−1, go to OUT.
- OUT: write C_flat from the accumulators via the output-conversion rule (see Configuration). Pulse done, then return to IDLE.
- A_flat and B_flat may change freely after the start edge; the captured copies are used.
- start while busy=1: ignored, no queuing.
- start held high: a new run is accepted on the first IDLE cycle, which is the cycle after done.
- acc_mode is ignored outside the start-sampling edge.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, k=0, C_flat=0, busy=0, done=0, accumulators=0. Captured operands are don't-care.
- Reset mid-run aborts the run with no done pulse. C_flat reads 0 after that edge.
- Edge E0 samples start. Edges E1..ET perform the MACs. Edge ET+1 updates C_flat and sets done=1.
- Latency from start to done is T+1 cycles, so N=4 gives 3.
- busy is 1 after E0 through the done cycle inclusive, and 0 on the cycle after done.
- C_flat changes only on the done edge or on reset.

## Configuration
- SYS_TILED_MM_SAT_EN defined: saturate each accumulator to OUT_W.
  - Unsigned range: [0, 2^OUT_W−1].
  - Signed range: [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- SYS_TILED_MM_SAT_EN undefined: truncate to the low OUT_W bits, with no saturation logic.

## Structure
- sys_mm_pkg holds:
  - the state enum (IDLE/MAC/OUT);
  - an ACC_W helper function;
  - element-index helpers (flat offset for (r,c) and for tile element (ti,tj,e)).
- Sub-module mat2x2_mac: combinational 2×2 tile product plus add of four ACC_W partial sums, parametrised by WIDTH, ACC_W and SIGNED. Instantiated T² times via generate.
- The top level owns the FSM, k counter, operand registers, accumulators and output conversion.

## Test plan
- Identity times B: N=4, A=I, B[e]=e+1, acc_mode=0 → done exactly 3 cycles after the start edge, C[e]=e+1, busy low on the following cycle.
- Accumulate: rerun with the same A and B and acc_mode=1 → C[e]=2·(e+1). A third run with acc_mode=0 → C[e]=e+1.
- Saturation vs truncation: WIDTH=16, OUT_W=16, unsigned, all A and B = 0x0100, so each element is 4·0x10000 = 0x40000 → C=0xFFFF with the macro, 0x0000 without.
- Signed: SIGNED=1, A=−1·I, B[e]=e → C[e]=−e, e.g. C[5]=16'hFFFB.
- Handshake and reset:
  - start pulse mid-run → ignored, exactly one done.
  - rst_n=0 on the second MAC cycle → no done, C_flat=0, busy=0.
  - A new start after reset completes normally.
- Generality: N=6, all elements 1 → done after 4 cycles, every C element = 6.
